command_serializer: RTL and testbench

//   Downstream stage of the command-sequencing controller.
//   - Consumes the controller's command word and start level.
//   - Answers on ready_command.
//   - Sends each accepted command as an asynchronous serial frame on tx, LSB first:

---
 rtl/command_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_command_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/command_serializer.sv
// command_serializer
//   Serialises each accepted command word into an asynchronous frame on tx,
//   LSB first: start bit, CMD_W data bits, optional even parity bit, then
//   STOP_BITS stop bits. Each serial bit lasts CLK_DIV clock cycles.
//
//   Optional feature macro: PARITY_EN
//     defined   -> an even parity bit follows the data bits
//     undefined -> no parity state or logic; data goes straight to stop
//
//   All outputs are registered: the next-state logic computes the value each
//   output takes in the next cycle, and one register stage drives the pins.
//   rst asserts asynchronously; its release is expected to be synchronised
//   to clk by the reset tree upstream of this block.

module command_serializer #(
    parameter int CLK_DIV   = 16,  // clk cycles per serial bit, >= 2
    parameter int CMD_W     = 3,   // command word width
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] command,
    input  logic             start,
    output logic             ready_command,
    output logic             tx,
    output logic             frame_done,
    output logic [7:0]       frames_sent
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(CMD_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_next;
    logic [CMD_W-1:0]   data_q;
    logic               load;
    logic               tx_next;
    logic               ready_next;
    logic               done_next;
`ifdef PARITY_EN
    logic               parity_q;
`endif

    // Next-state logic: bit sequencing, divider, and next-cycle output values.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        load       = 1'b0;
        tx_next    = 1'b1;
        ready_next = 1'b0;
        done_next  = 1'b0;

        if (state == IDLE) begin
            // ready_command is registered, so acceptance never depends
            // combinationally on start reaching an output.
            if (start && ready_command) begin
                state_next = START;
                div_next   = '0;
                bit_next   = '0;
                load       = 1'b1;
            end
        end else if (div_cnt == DIV_LAST) begin
            // End of the current serial bit: move to the next one.
            div_next = '0;
            case (state)
                START: begin
                    state_next = DATA;
                    bit_next   = '0;
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                        bit_next = '0;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    state_next = STOP;
                    bit_next   = '0;
                end
`endif
                STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        state_next = IDLE;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    bit_next   = '0;
                end
            endcase
        end else begin
            div_next = div_cnt + 1'b1;
        end

        // Output values for the cycle that follows this edge.
        case (state_next)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
            START: begin
                tx_next = 1'b0;
            end
            DATA: begin
                tx_next = data_q[bit_next];
            end
`ifdef PARITY_EN
            PARITY: begin
                tx_next = parity_q;
            end
`endif
            STOP: begin
                tx_next   = 1'b1;
                done_next = (div_next == DIV_LAST) && (bit_next == STOP_LAST);
            end
            default: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            ready_command <= 1'b1;
            tx            <= 1'b1;
            frame_done    <= 1'b0;
            frames_sent   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, so the order of these statements does not matter.
            state         <= state_next;
            div_cnt       <= div_next;
            bit_cnt       <= bit_next;
            ready_command <= ready_next;
            tx            <= tx_next;
            frame_done    <= done_next;
            if (done_next) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end

    // Command latch: captured once at acceptance and held for the whole frame,
    // so changes on command mid-frame never reach the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= command;
        end
    end

`ifdef PARITY_EN
    // Even parity of the latched word, captured alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^command;
        end
    end
`endif

endmodule

// File: tb/tb_command_serializer.sv
// tb_command_serializer
//   Table-driven vectors, hand-written corner sequences and randomised frames
//   for command_serializer. Expected waveforms come from a frame model that
//   lists the serial bits of a frame and expands each one to CLK_DIV cycles.

module tb_command_serializer;

    localparam int CLK_DIV   = 4;
    localparam int CMD_W     = 3;
    localparam int STOP_BITS = 1;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (1 + CMD_W + P + STOP_BITS) * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CMD_W-1:0] command = '0;
    logic             start = 1'b0;
    logic             ready_command;
    logic             tx;
    logic             frame_done;
    logic [7:0]       frames_sent;

    int checks = 0;
    int errors = 0;
    int fs_model = 0;
    int done_total = 0;

    typedef struct {
        logic [CMD_W-1:0] cmd;
        logic             parity;  // hand-computed even parity of cmd
    } vec_t;

    command_serializer #(
        .CLK_DIV  (CLK_DIV),
        .CMD_W    (CMD_W),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .start        (start),
        .ready_command(ready_command),
        .tx           (tx),
        .frame_done   (frame_done),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle tx of one frame: bit k is the line level in frame cycle k.
    function automatic logic [63:0] frame_pattern(input logic [CMD_W-1:0] cmd, input logic par);
        logic [63:0] p;
        bit          seq[$];
        p = '0;
        seq.push_back(1'b0);
        for (int i = 0; i < CMD_W; i++) seq.push_back(cmd[i]);
        if (P == 1) seq.push_back(par);
        for (int s = 0; s < STOP_BITS; s++) seq.push_back(1'b1);
        foreach (seq[j]) begin
            for (int c = 0; c < CLK_DIV; c++) p[j*CLK_DIV + c] = seq[j];
        end
        return p;
    endfunction

    // Launch one frame and check its whole waveform. hold keeps start high
    // afterwards; at frame cycle chg_k the command (and start, if not held)
    // is disturbed to show the latched value is used.
    task automatic run_frame(input logic [CMD_W-1:0] cmd, input logic par, input bit hold,
                             input int chg_k, input logic [CMD_W-1:0] chg_cmd,
                             input logic chg_start, input string tag);
        logic [63:0] got;
        int          low;
        int          dones;
        int          done_at;
        if (!start) begin
            for (int i = 0; i < 100 && !ready_command; i++) step();
        end
        check({tag, "_ready_at_entry"}, 64'(ready_command), 64'd1);
        command = cmd;
        start   = 1'b1;
        step();
        if (!hold) start = 1'b0;
        got = '0; low = 0; dones = 0; done_at = -1;
        for (int k = 0; k < F; k++) begin
            got[k] = tx;
            if (!ready_command) low++;
            if (frame_done) begin
                dones++;
                done_at = k;
            end
            if (k == chg_k) begin
                command = chg_cmd;
                if (!hold) start = chg_start;
            end
            step();
        end
        fs_model++;
        check({tag, "_tx"}, got, frame_pattern(cmd, par));
        check({tag, "_ready_low"}, 64'(low), 64'(F));
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_done_pos"}, 64'(done_at), 64'(F - 1));
        check({tag, "_ready_after"}, 64'(ready_command), 64'd1);
        check({tag, "_frames_sent"}, 64'(frames_sent), 64'(fs_model % 256));
    endtask

    vec_t vecs[8];

    initial begin
        logic [CMD_W-1:0] rc;
        logic [CMD_W-1:0] rchg;
        bit               rhold;
        int               d0;

        vecs[0] = '{3'b101, 1'b0};
        vecs[1] = '{3'b100, 1'b1};
        vecs[2] = '{3'b000, 1'b0};
        vecs[3] = '{3'b111, 1'b1};
        vecs[4] = '{3'b011, 1'b0};
        vecs[5] = '{3'b110, 1'b0};
        vecs[6] = '{3'b001, 1'b1};
        vecs[7] = '{3'b010, 1'b1};

        // Reset state while rst is held.
        step();
        step();
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_ready", 64'(ready_command), 64'd1);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        rst = 1'b0;

        // start low in idle: nothing happens.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_tx", 64'(tx), 64'd1);
            check("idle_ready", 64'(ready_command), 64'd1);
        end

        // Basic frame, command 3'b101, single-cycle start pulse.
        run_frame(3'b101, 1'b0, 1'b0, -1, '0, 1'b0, "basic");

        // rst in the 9th cycle of a frame aborts at once.
        command = 3'b011;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("abort_pre_ready", 64'(ready_command), 64'd0);
        rst = 1'b1;
        #1;
        fs_model = 0;
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_ready", 64'(ready_command), 64'd1);
        check("abort_done", 64'(frame_done), 64'd0);
        check("abort_frames", 64'(frames_sent), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("abort_idle_tx", 64'(tx), 64'd1);
        run_frame(3'b110, 1'b0, 1'b0, -1, '0, 1'b0, "after_abort");

        // Table vectors with hand-computed parity.
        foreach (vecs[i]) begin
            run_frame(vecs[i].cmd, vecs[i].parity, 1'b0, -1, '0, 1'b0, "table");
            step();
        end

        // start held high, command stepping 0..7: back-to-back frames.
        for (int c = 0; c < 8; c++) begin
            rc = CMD_W'(c);
            run_frame(rc, ^rc, (c < 7), -1, '0, 1'b0, "stream");
        end

        // Command (and start) change in the second data bit is ignored.
        run_frame(3'b011, 1'b0, 1'b0, 2*CLK_DIV + 1, 3'b110, 1'b1, "cmd_change");
        start = 1'b0;

        // Randomised frames with random gaps, holds and mid-frame disturbance.
        for (int r = 0; r < 40; r++) begin
            rc    = CMD_W'($urandom);
            rchg  = CMD_W'($urandom);
            rhold = (r < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_frame(rc, ^rc, rhold, int'($urandom_range(0, F - 1)), rchg,
                      1'($urandom_range(0, 1)), "rand");
            if (!rhold) begin
                start = 1'b0;
                repeat ($urandom_range(0, 4)) begin
                    check("rand_gap_tx", 64'(tx), 64'd1);
                    check("rand_gap_ready", 64'(ready_command), 64'd1);
                    step();
                end
            end
        end
        start = 1'b0;
        step();

        // 256 frames from reset: counter reaches 255 then wraps to 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fs_model = 0;
        step();
        d0 = done_total;
        for (int n = 0; n < 256; n++) begin
            rc = CMD_W'(n);
            run_frame(rc, ^rc, (n < 255), -1, '0, 1'b0, "wrap");
            if (n == 254) check("wrap_at_255", 64'(frames_sent), 64'd255);
        end
        check("wrap_to_zero", 64'(frames_sent), 64'd0);
        check("wrap_done_total", 64'(done_total - d0), 64'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
